// File: rtl/icache_direct_if.sv
// Fetch-side and refill-side signals of the direct-mapped I-cache.
// slave = cache, master = ifetch + memory controller.
interface icache_direct_if;
  logic [31:0] IC_addr;
  logic        IC_addr_sgn;
  logic        pc_change;
  logic        IC_ins_sgn;
  logic [31:0] IC_ins;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid;
  logic [7:0]  mc_byte;

  modport slave (
    input  IC_addr, IC_addr_sgn, pc_change,
    input  mc_valid, mc_byte,
    output IC_ins_sgn, IC_ins,
    output mc_req, mc_addr
  );

  modport master (
    output IC_addr, IC_addr_sgn, pc_change,
    output mc_valid, mc_byte,
    input  IC_ins_sgn, IC_ins,
    input  mc_req, mc_addr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with byte-serial line refill.
// A refill always completes, then the current PC is looked up again.
module icache_direct #(
  parameter int INDEX_BITS  = 5,
  parameter int OFFSET_BITS = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  icache_direct_if.slave  bus
);
  localparam int LINES  = 1 << INDEX_BITS;
  localparam int LBYTES = 1 << OFFSET_BITS;
  localparam int TAG_W  = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int IDX_LO = OFFSET_BITS;
  localparam int TAG_LO = OFFSET_BITS + INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    REFILL,
    WAIT
  } state_t;

  state_t state, state_nx;

  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tags [LINES];
  logic [7:0]             mem  [LINES][LBYTES];
  logic [OFFSET_BITS-1:0] cnt;
  logic [31:0]            ins_q;
  logic                   req_q;
  logic [31:0]            addr_q;

  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_W-1:0]       tag;
  logic [OFFSET_BITS-1:0] boff;
  logic                   hit;
  logic [31:0]            word;
  logic [INDEX_BITS-1:0]  ridx;
  logic [TAG_W-1:0]       rtag;
  logic                   last;
  logic                   unused_pc;

  // pc_change needs no action: refills never abort and
  // RESP/WAIT are already committed.
  assign unused_pc = bus.pc_change;

  assign idx  = bus.IC_addr[TAG_LO-1:IDX_LO];
  assign tag  = bus.IC_addr[31:TAG_LO];
  assign boff = bus.IC_addr[OFFSET_BITS-1:0]
              & ~OFFSET_BITS'(3);
  assign hit  = valid[idx] && (tags[idx] == tag);

  assign word = {mem[idx][boff + OFFSET_BITS'(3)],
                 mem[idx][boff + OFFSET_BITS'(2)],
                 mem[idx][boff + OFFSET_BITS'(1)],
                 mem[idx][boff]};

  // Refill target comes from the latched line address,
  // so a PC redirect mid-refill cannot retarget it.
  assign ridx = addr_q[TAG_LO-1:IDX_LO];
  assign rtag = addr_q[31:TAG_LO];
  assign last = (cnt == {OFFSET_BITS{1'b1}});

  assign bus.IC_ins_sgn = (state == RESP);
  assign bus.IC_ins     = ins_q;
  assign bus.mc_req     = req_q;
  assign bus.mc_addr    = addr_q;

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.IC_addr_sgn)
          state_nx = hit ? RESP : REFILL;
      end
      RESP:   state_nx = WAIT;
      WAIT:   state_nx = IDLE;
      REFILL: begin
        if (bus.mc_valid && last)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, frozen while rdy is low
  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else if (rdy)
      state <= state_nx;
  end

  // Control registers: valid bits, output word, refill request
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid  <= '0;
      ins_q  <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
      cnt    <= '0;
    end else if (rdy) begin
      unique case (state)
        IDLE: begin
          if (bus.IC_addr_sgn) begin
            if (hit) begin
              ins_q <= word;
            end else begin
              addr_q <= {bus.IC_addr[31:OFFSET_BITS],
                         {OFFSET_BITS{1'b0}}};
              req_q  <= 1'b1;
              cnt    <= '0;
              valid[idx] <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (bus.mc_valid) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              valid[ridx] <= 1'b1;
              req_q       <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage and tags; no reset needed, gated by valid
  always_ff @(posedge clk) begin
    if (rst && rdy && state == REFILL && bus.mc_valid) begin
      mem[ridx][cnt] <= bus.mc_byte;
      if (last)
        tags[ridx] <= rtag;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: refill, hit, eviction,
// redirect during refill, rdy stall and reset mid-refill.
module tb_icache_direct;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  int   errors = 0;
  int   checks = 0;

  localparam logic [127:0] L0 = {
    32'h00300193, 32'h00200113,
    32'h00100093, 32'h00000013};
  localparam logic [127:0] L200 = {
    32'h0BADF00D, 32'hDEADBEEF,
    32'h00000073, 32'h12345678};
  localparam logic [127:0] L40 = {
    32'h44332211, 32'h88776655,
    32'h01020304, 32'hCAFEF00D};

  icache_direct_if ifc ();

  icache_direct #(
    .INDEX_BITS (5),
    .OFFSET_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fill(input logic [127:0] line,
                      input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      ifc.mc_valid = 1'b1;
      ifc.mc_byte  = line[8*i +: 8];
      step();
      ifc.mc_valid = 1'b0;
      chk("refill_nopulse", ifc.IC_ins_sgn, 0);
      chk("refill_req", ifc.mc_req, (i < 15) ? 1 : 0);
    end
  endtask

  initial begin
    ifc.IC_addr     = 32'h0;
    ifc.IC_addr_sgn = 1'b0;
    ifc.pc_change   = 1'b0;
    ifc.mc_valid    = 1'b0;
    ifc.mc_byte     = 8'h0;
    rst = 1'b0;
    rdy = 1'b1;
    repeat (3) step();
    chk("rst_sgn", ifc.IC_ins_sgn, 0);
    chk("rst_ins", ifc.IC_ins, 0);
    chk("rst_req", ifc.mc_req, 0);
    chk("rst_addr", ifc.mc_addr, 0);

    // cold miss on 0x0
    rst = 1'b1;
    ifc.IC_addr_sgn = 1'b1;
    step();
    chk("miss0_req", ifc.mc_req, 1);
    chk("miss0_addr", ifc.mc_addr, 32'h0);
    chk("miss0_sgn", ifc.IC_ins_sgn, 0);

    fill(L0, 0, 16);
    step();
    chk("hit0_sgn", ifc.IC_ins_sgn, 1);
    chk("hit0_ins", ifc.IC_ins, 32'h00000013);

    // sequential step to 0x4
    ifc.IC_addr   = 32'h4;
    ifc.pc_change = 1'b1;
    step();
    ifc.pc_change = 1'b0;
    chk("bubble0", ifc.IC_ins_sgn, 0);
    step();
    chk("idle0", ifc.IC_ins_sgn, 0);
    step();
    chk("hit4_sgn", ifc.IC_ins_sgn, 1);
    chk("hit4_ins", ifc.IC_ins, 32'h00100093);
    chk("hit4_req", ifc.mc_req, 0);

    // conflict: 0x200 shares index 0
    ifc.IC_addr   = 32'h200;
    ifc.pc_change = 1'b1;
    step();
    ifc.pc_change = 1'b0;
    chk("hit4_once", ifc.IC_ins_sgn, 0);
    chk("hit4_noreq", ifc.mc_req, 0);
    step();
    step();
    chk("miss200_req", ifc.mc_req, 1);
    chk("miss200_addr", ifc.mc_addr, 32'h200);
    fill(L200, 0, 16);
    step();
    chk("hit200_sgn", ifc.IC_ins_sgn, 1);
    chk("hit200_ins", ifc.IC_ins, 32'h12345678);

    // 0x0 was evicted
    ifc.IC_addr = 32'h0;
    step();
    step();
    step();
    chk("evict_req", ifc.mc_req, 1);
    chk("evict_addr", ifc.mc_addr, 32'h0);
    chk("evict_sgn", ifc.IC_ins_sgn, 0);

    // redirect to 0x40 during refill of 0x0
    fill(L0, 0, 5);
    ifc.IC_addr   = 32'h40;
    ifc.pc_change = 1'b1;
    fill(L0, 5, 6);
    ifc.pc_change = 1'b0;
    fill(L0, 6, 16);
    step();
    chk("redir_sgn", ifc.IC_ins_sgn, 0);
    chk("redir_req", ifc.mc_req, 1);
    chk("redir_addr", ifc.mc_addr, 32'h40);

    // stall 3 cycles after 7 bytes, with junk on mc_valid
    fill(L40, 0, 7);
    rdy = 1'b0;
    ifc.mc_valid = 1'b1;
    ifc.mc_byte  = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_req", ifc.mc_req, 1);
      chk("stall_sgn", ifc.IC_ins_sgn, 0);
    end
    ifc.mc_valid = 1'b0;
    rdy = 1'b1;
    fill(L40, 7, 16);
    step();
    chk("hit40_sgn", ifc.IC_ins_sgn, 1);
    chk("hit40_ins", ifc.IC_ins, 32'hCAFEF00D);

    // line 0x0 was installed despite redirect
    ifc.IC_addr = 32'h8;
    step();
    step();
    step();
    chk("hit8_sgn", ifc.IC_ins_sgn, 1);
    chk("hit8_ins", ifc.IC_ins, 32'h00200113);
    chk("hit8_req", ifc.mc_req, 0);

    // reset in the middle of a refill
    ifc.IC_addr = 32'h200;
    step();
    step();
    step();
    chk("miss200b_req", ifc.mc_req, 1);
    fill(L200, 0, 3);
    rst = 1'b0;
    step();
    chk("midrst_req", ifc.mc_req, 0);
    chk("midrst_addr", ifc.mc_addr, 32'h0);
    chk("midrst_ins", ifc.IC_ins, 32'h0);
    chk("midrst_sgn", ifc.IC_ins_sgn, 0);
    rst = 1'b1;
    ifc.IC_addr = 32'h40;
    step();
    chk("inval40_req", ifc.mc_req, 1);
    chk("inval40_addr", ifc.mc_addr, 32'h40);
    chk("inval40_sgn", ifc.IC_ins_sgn, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
